picorv32_alu_mc: RTL and testbench
==================================

// Module: picorv32_alu_mc
// PURPOSE
//  Multi-cycle, width-parametrised ALU for the modular picorv32 datapath with valid/ready handshakes.
//  Sits between the FSM/decoder and the register-writeback path.
//  Adds to the combinational ALU:
//   - an encoded opcode;
//   - an iterative shifter (SLL/SRL/SRA);
//   - a registered, back-pressurable result.
//  Non-shift ops complete in 1 cycle; shifts take a latency that depends on the shift amount.
// PARAMETERS
//  XLEN        32  operand/result width; power of 2, >= 8
//  SHIFT_STEP  4   bits shifted per coarse step; power of 2, 1..XLEN
// PORTS
//  clk         in   1     clock, all state on rising edge
//  resetn      in   1     synchronous, active-low reset
//  in_valid    in   1     op/op1/op2 valid
//  in_ready    out  1     block can accept a new operation
//  op          in   4     0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLT, 6 SLTU, 7 EQ, 8 NE,
//                         9 GE, 10 GEU, 11 SLL, 12 SRL, 13 SRA, 14-15 reserved
//  op1         in   XLEN  first operand
//  op2         in   XLEN  second operand; shamt = op2[$clog2(XLEN)-1:0]
//  out_valid   out  1     out_result/out_cmp valid
//  out_ready   in   1     consumer accepts the result
//  out_result  out  XLEN  ALU result
//  out_cmp     out  1     compare/branch outcome
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, out_result=0, out_cmp=0, internal count=0.
//   - in_ready=1 in the first cycle after reset is released.
//   - Reset in any state aborts the operation in progress; no output is produced for it.
//  FSM states: IDLE, SHIFT, DONE.
//   - in_ready = (state==IDLE) || (state==DONE && out_ready).
//   - Accept = in_valid && in_ready at a clock edge; op, op1 and op2 are captured at that edge.
//  Accepting a non-shift op, or a shift with shamt==0:
//   - The result is computed and registered; next state is DONE.
//   - out_valid is asserted in the cycle after the accept edge (latency 1).
//  Accepting a shift with shamt!=0:
//   - Next state is SHIFT; op1 goes into the work register and count=shamt.
//   - Each SHIFT cycle: if count>=SHIFT_STEP, shift by SHIFT_STEP and count-=SHIFT_STEP;
//     otherwise shift by 1 and count-=1.
//   - The edge that brings count to 0 moves the FSM to DONE.
//   - N = floor(shamt/SHIFT_STEP) + (shamt mod SHIFT_STEP) SHIFT cycles.
//   - out_valid rises N+1 cycles after the accept edge.
//  DONE:
//   - out_valid=1; out_result and out_cmp are held stable while out_ready=0.
//   - out_ready=1 with in_valid=0: next state IDLE, out_valid=0.
//   - out_ready=1 with in_valid=1: the new op is accepted in the same cycle (back-to-back).
//     Non-shift ops then sustain one result per cycle.
//  Arithmetic, all modulo 2^XLEN:
//   - ADD/SUB wrap around; carry and borrow are discarded.
//   - SLL and SRL fill with zeros; SRA fills with op1[XLEN-1].
//  out_cmp:
//   - EQ: op1==op2; NE: !EQ.
//   - SLT: signed op1<op2; SLTU: unsigned op1<op2.
//   - GE: !SLT; GEU: !SLTU.
//   - Any other op: 0.
//  out_result:
//   - Compare ops (5-10): {XLEN-1 zeros, out_cmp}.
//   - Reserved ops 14-15: result 0, cmp 0, latency 1 (never X).
//  in_valid=0 in IDLE leaves all registers unchanged. Inputs are ignored while in SHIFT.
// TESTING
//  T1: XLEN=32, ADD 0xFFFFFFFF+0x1 -> out_result=0x0 one cycle after accept.
//      SUB 0x0-0x1 -> 0xFFFFFFFF.
//  T2: SLT 0xFFFFFFFF,0x1 -> cmp=1, result=0x1.
//      SLTU with the same operands -> cmp=0, result=0x0.
//      GEU 5,5 -> cmp=1; NE 5,5 -> cmp=0.
//  T3: SHIFT_STEP=4, SRA 0x80000000 by 7 -> 0xFF000000, out_valid 5 cycles after accept.
//      SLL 0x1 by 31 -> 0x80000000 after 11 cycles.
//      SRL by 0 -> op1 after 1 cycle.
//  T4: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_result and out_cmp stable;
//      in_ready=0 throughout.
//  T5: stream 8 ADDs with out_ready=1 -> one result per cycle in order, in_ready stays 1.
//  T6: resetn=0 for 1 cycle mid-SHIFT -> out_valid=0, outputs 0, in_ready=1 the following cycle.
//      A new XOR 0xF0F0,0x0FF0 -> 0xFF00.

Source files
------------

// File: rtl/picorv32_alu_mc_if.sv
// Handshake bundle between the decoder/FSM and the multi-cycle ALU.
// The operation channel (in_*) and the result channel (out_*) each use valid/ready.
interface picorv32_alu_mc_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_cmp;

  // Side that issues operations and consumes results.
  modport master (
    output in_valid, op, op1, op2, out_ready,
    input  in_ready, out_valid, out_result, out_cmp
  );

  // The ALU itself.
  modport slave (
    input  in_valid, op, op1, op2, out_ready,
    output in_ready, out_valid, out_result, out_cmp
  );
endinterface

// File: rtl/picorv32_alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare, iterative shifter that
// moves SHIFT_STEP bits per cycle while enough shift distance remains, then 1 bit
// per cycle. The result sits in a register until the consumer takes it.
module picorv32_alu_mc #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  picorv32_alu_mc_if.slave       bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_NE   = 4'd8;
  localparam logic [3:0] OP_GE   = 4'd9;
  localparam logic [3:0] OP_GEU  = 4'd10;
  localparam logic [3:0] OP_SLL  = 4'd11;
  localparam logic [3:0] OP_SRL  = 4'd12;
  localparam logic [3:0] OP_SRA  = 4'd13;

  // Coarse-step threshold, one bit wider than the count so SHIFT_STEP==XLEN still fits.
  localparam logic [SHW:0]   STEP_WIDE = (SHW+1)'(SHIFT_STEP);
  localparam logic [SHW-1:0] STEP_CNT  = SHW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [SHW-1:0]  count_reg, count_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            cmp_reg, cmp_next;
  logic [3:0]      op_reg, op_next;

  logic            in_ready;
  logic            accept;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_result;
  logic            alu_cmp;
  logic            coarse;
  logic [XLEN-1:0] shift_result;
  logic [SHW-1:0]  shift_count;

  assign shamt    = bus.op2[SHW-1:0];
  assign is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);

  // Single-cycle result for everything except a shift by a nonzero amount.
  always_comb begin
    logic eq, lt, ltu;
    eq         = (bus.op1 == bus.op2);
    lt         = ($signed(bus.op1) < $signed(bus.op2));
    ltu        = (bus.op1 < bus.op2);
    alu_result = '0;
    alu_cmp    = 1'b0;
    case (bus.op)
      OP_ADD:  alu_result = bus.op1 + bus.op2;
      OP_SUB:  alu_result = bus.op1 - bus.op2;
      OP_XOR:  alu_result = bus.op1 ^ bus.op2;
      OP_OR:   alu_result = bus.op1 | bus.op2;
      OP_AND:  alu_result = bus.op1 & bus.op2;
      OP_SLT:  alu_cmp = lt;
      OP_SLTU: alu_cmp = ltu;
      OP_EQ:   alu_cmp = eq;
      OP_NE:   alu_cmp = !eq;
      OP_GE:   alu_cmp = !lt;
      OP_GEU:  alu_cmp = !ltu;
      // Shift by zero passes op1 straight through.
      OP_SLL, OP_SRL, OP_SRA: alu_result = bus.op1;
      default: alu_result = '0;
    endcase
    if (bus.op >= OP_SLT && bus.op <= OP_GEU)
      alu_result = {{(XLEN-1){1'b0}}, alu_cmp};
  end

  // One shifter iteration on the work register: coarse step while distance allows.
  always_comb begin
    coarse       = ({1'b0, count_reg} >= STEP_WIDE);
    shift_result = result_reg;
    shift_count  = count_reg;
    if (coarse) begin
      shift_count = count_reg - STEP_CNT;
      case (op_reg)
        OP_SLL:  shift_result = result_reg << SHIFT_STEP;
        OP_SRL:  shift_result = result_reg >> SHIFT_STEP;
        default: shift_result = $signed(result_reg) >>> SHIFT_STEP;
      endcase
    end else begin
      shift_count = count_reg - 1'b1;
      case (op_reg)
        OP_SLL:  shift_result = result_reg << 1;
        OP_SRL:  shift_result = result_reg >> 1;
        default: shift_result = $signed(result_reg) >>> 1;
      endcase
    end
  end

  // Next-state and handshake logic for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    result_next = result_reg;
    cmp_next    = cmp_reg;
    op_next     = op_reg;
    in_ready    = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    accept      = bus.in_valid && in_ready;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          op_next = bus.op;
          if (is_shift && (shamt != '0)) begin
            state_next  = SHIFT;
            result_next = bus.op1;
            count_next  = shamt;
            cmp_next    = 1'b0;
          end else begin
            state_next  = DONE;
            result_next = alu_result;
            cmp_next    = alu_cmp;
          end
        end else if (state_reg == DONE && bus.out_ready) begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        result_next = shift_result;
        count_next  = shift_count;
        if (shift_count == '0)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      result_reg <= '0;
      cmp_reg    <= 1'b0;
      op_reg     <= 4'd0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      result_reg <= result_next;
      cmp_reg    <= cmp_next;
      op_reg     <= op_next;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.out_result = result_reg;
  assign bus.out_cmp    = cmp_reg;
endmodule

// File: tb/tb_picorv32_alu_mc.sv
// Directed bench for picorv32_alu_mc: expected results go into a scoreboard queue
// when an op is issued and are popped when out_valid is seen.
module tb_picorv32_alu_mc;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        cmp;
  } exp_t;
  exp_t sb[$];

  picorv32_alu_mc_if #(.XLEN(32)) bus ();

  picorv32_alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Issue one op, wait for its result, optionally hold out_ready low, then drain.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic cmp, input int lat, input int hold);
    exp_t e;
    int   cycles;
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.op1       = a;
    bus.op2       = b;
    bus.out_ready = 1'b0;
    sb.push_back('{res, cmp});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op1      = $urandom;
    bus.op2      = $urandom;
    cycles       = 1;
    if (lat > 1) check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    while (bus.out_valid !== 1'b1 && cycles < 64) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", 32'(cycles), 32'(lat));
    e = sb.pop_front();
    check("result", bus.out_result, e.res);
    check("cmp", 32'(bus.out_cmp), 32'(e.cmp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", bus.out_result, e.res);
      check("hold_cmp", 32'(bus.out_cmp), 32'(e.cmp));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    $display("txn op=%0d op1=0x%08h op2=0x%08h result=0x%08h cmp=%0b latency=%0d",
             op, a, b, bus.out_result, bus.out_cmp, cycles);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    exp_t        e;
    logic [31:0] a, b;

    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.out_result, 32'd0);
    check("rst_cmp", 32'(bus.out_cmp), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // T1: wrapping arithmetic
    run_op(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0);
    run_op(4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1, 0);
    run_op(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1, 0);
    run_op(4'd3, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1, 0);
    // Reserved op gives zeros even after a nonzero result
    run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0, 1, 0);

    // T2: compares
    run_op(4'd5, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1, 1, 0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0);
    run_op(4'd10, 32'd5, 32'd5, 32'h1, 1'b1, 1, 0);
    run_op(4'd8, 32'd5, 32'd5, 32'h0, 1'b0, 1, 0);
    run_op(4'd7, 32'd5, 32'd5, 32'h1, 1'b1, 1, 0);
    run_op(4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0);

    // T3: shifts, latency = floor(shamt/4) + shamt%4 + 1
    run_op(4'd13, 32'h8000_0000, 32'd7, 32'hFF00_0000, 1'b0, 5, 0);
    run_op(4'd11, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 11, 0);
    run_op(4'd12, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1, 0);
    run_op(4'd12, 32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, 2, 0);
    run_op(4'd13, 32'h8000_0000, 32'd3, 32'hF000_0000, 1'b0, 4, 0);
    run_op(4'd13, 32'h4000_0000, 32'd30, 32'h1, 1'b0, 10, 0);

    // T4: back-pressure held for 10 cycles
    run_op(4'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b1, 1, 10);

    // T5: eight back-to-back ADDs
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        check("stream_valid", 32'(bus.out_valid), 32'd1);
        e = sb.pop_front();
        check("stream_result", bus.out_result, e.res);
        $display("txn stream idx=%0d result=0x%08h", i - 1, bus.out_result);
      end
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      a = 32'h1111_1111 * 32'(i);
      b = 32'hF000_0000 + 32'(i);
      bus.in_valid = 1'b1;
      bus.op       = 4'd0;
      bus.op1      = a;
      bus.op2      = b;
      sb.push_back('{a + b, 1'b0});
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("stream_valid", 32'(bus.out_valid), 32'd1);
    e = sb.pop_front();
    check("stream_result", bus.out_result, e.res);
    $display("txn stream idx=7 result=0x%08h", bus.out_result);
    @(negedge clk);
    check("stream_drain", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // T6: reset in the middle of a long shift
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 4'd11;
    bus.op1      = 32'h1;
    bus.op2      = 32'd31;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_shift_busy", 32'(bus.in_ready), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", bus.out_result, 32'd0);
    check("abort_cmp", 32'(bus.out_cmp), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    $display("txn aborted SLL by reset");
    run_op(4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
